// File: rtl/pulpemu_rst_pkg.sv
// Shared types and helpers for the emulation-top reset sequencer.
package pulpemu_rst_pkg;

    // Sequencer states: hold everything in reset, release domains one by one, run.
    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } rst_state_e;

    // Cause bit offsets above the N_SRC per-source bits.
    localparam int CAUSE_LOCK = 0;
    localparam int CAUSE_POR  = 1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // One counter width wide enough for every delay count in the sequencer.
    function automatic int cnt_width(input int a, input int b, input int c);
        return $clog2(max3(a, b, c) + 1);
    endfunction

endpackage

// File: rtl/pulpemu_rst_filter.sv
// One reset request line: 2-FF synchroniser, polarity normalisation and a
// deassertion debounce. Assertion passes straight through; release needs
// DEBOUNCE_CYCLES consecutive inactive synchronised samples.
module pulpemu_rst_filter #(
    parameter bit ACT_LOW         = 1'b0,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_raw_i,
    output logic req_o
);

    // Raw pad level that means "requesting"; the synchroniser powers up there.
    localparam logic REQ_LVL = ACT_LOW ? 1'b0 : 1'b1;

    logic             sync_p0;
    logic             sync_p1;
    logic             req_sync;
    logic             held;
    logic [CNT_W-1:0] cnt;

    // Two-stage synchroniser for the asynchronous request pin.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_p0 <= REQ_LVL;
            sync_p1 <= REQ_LVL;
        end else begin
            sync_p0 <= req_raw_i;
            sync_p1 <= sync_p0;
        end
    end

    assign req_sync = sync_p1 ^ ACT_LOW;

    // Keep the request held until enough consecutive inactive samples are seen.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            held <= 1'b1;
            cnt  <= '0;
        end else if (req_sync) begin
            held <= 1'b1;
            cnt  <= '0;
        end else if (held) begin
            if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                held <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Active samples are forwarded without waiting for the held flop.
    assign req_o = req_sync | held;

endmodule

// File: rtl/pulpemu_rst_seq.sv
// Reset sequencer for the FPGA emulation top: filters the pad requests and
// clock-lock loss, holds all domains in reset for a minimum time, releases the
// domains one at a time and records which request caused the last reset.
module pulpemu_rst_seq
    import pulpemu_rst_pkg::*;
#(
    parameter int               N_SRC           = 2,
    parameter logic [N_SRC-1:0] SRC_ACT_LOW     = 2'b10,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter int               HOLD_CYCLES     = 16,
    parameter int               N_DOM           = 3,
    parameter int               STAGE_DELAY     = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [N_SRC-1:0]   src_i,
    input  logic               lock_i,
    input  logic               cause_clr_i,
    output logic [N_DOM-1:0]   rst_no,
    output logic               done_o,
    output logic [N_SRC+1:0]   cause_o
);

    localparam int CNT_W    = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES, STAGE_DELAY);
    localparam int IDX_W    = (N_DOM > 1) ? $clog2(N_DOM) : 1;
    localparam int N_REQ    = N_SRC + 1;
    localparam int LOCK_BIT = N_SRC + CAUSE_LOCK;
    localparam int POR_BIT  = N_SRC + CAUSE_POR;
    localparam logic [N_SRC+1:0] CAUSE_RST = (N_SRC+2)'(1) << POR_BIT;

    logic [N_REQ-1:0] filt_req;
    logic [N_REQ-1:0] filt_q;
    logic [N_REQ-1:0] filt_rise;
    logic             any_req;
    logic [N_SRC+1:0] cause_n;

    rst_state_e       state_q;
    rst_state_e       state_n;
    logic [CNT_W-1:0] hold_cnt_q;
    logic [CNT_W-1:0] hold_cnt_n;
    logic [CNT_W-1:0] stage_cnt_q;
    logic [CNT_W-1:0] stage_cnt_n;
    logic [IDX_W-1:0] stage_idx_q;
    logic [IDX_W-1:0] stage_idx_n;
    logic [N_DOM-1:0] rst_no_n;
    logic             done_n;

    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
        pulpemu_rst_filter #(
            .ACT_LOW         (SRC_ACT_LOW[gi]),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_filt (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .req_raw_i (src_i[gi]),
            .req_o     (filt_req[gi])
        );
    end

    // Lock loss is a request: the locked pin is treated as an active-low source.
    pulpemu_rst_filter #(
        .ACT_LOW         (1'b1),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_lock_filt (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_raw_i (lock_i),
        .req_o     (filt_req[LOCK_BIT])
    );

    assign any_req = |filt_req;

    // Sequencer state, counters and registered reset outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_HOLD;
            hold_cnt_q  <= '0;
            stage_cnt_q <= '0;
            stage_idx_q <= '0;
            rst_no      <= '0;
            done_o      <= 1'b0;
        end else begin
            state_q     <= state_n;
            hold_cnt_q  <= hold_cnt_n;
            stage_cnt_q <= stage_cnt_n;
            stage_idx_q <= stage_idx_n;
            rst_no      <= rst_no_n;
            done_o      <= done_n;
        end
    end

    // Next state: any request drops back to HOLD; release is staged and monotonic.
    always_comb begin
        state_n     = state_q;
        hold_cnt_n  = hold_cnt_q;
        stage_cnt_n = stage_cnt_q;
        stage_idx_n = stage_idx_q;
        rst_no_n    = '0;
        done_n      = 1'b0;

        case (state_q)
            ST_HOLD: begin
                if (any_req) begin
                    hold_cnt_n = '0;
                end else if (hold_cnt_q == CNT_W'(HOLD_CYCLES)) begin
                    hold_cnt_n  = '0;
                    stage_cnt_n = '0;
                    stage_idx_n = '0;
                    state_n     = (N_DOM == 1) ? ST_RUN : ST_RELEASE;
                end else begin
                    hold_cnt_n = hold_cnt_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (any_req) begin
                    state_n     = ST_HOLD;
                    hold_cnt_n  = '0;
                    stage_cnt_n = '0;
                    stage_idx_n = '0;
                end else if (stage_cnt_q == CNT_W'(STAGE_DELAY - 1)) begin
                    stage_cnt_n = '0;
                    stage_idx_n = stage_idx_q + 1'b1;
                    if (stage_idx_q == IDX_W'(N_DOM - 2)) begin
                        state_n = ST_RUN;
                    end
                end else begin
                    stage_cnt_n = stage_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (any_req) begin
                    state_n     = ST_HOLD;
                    hold_cnt_n  = '0;
                    stage_cnt_n = '0;
                    stage_idx_n = '0;
                end
            end
            default: begin
                state_n     = ST_HOLD;
                hold_cnt_n  = '0;
                stage_cnt_n = '0;
                stage_idx_n = '0;
            end
        endcase

        for (int k = 0; k < N_DOM; k++) begin
            rst_no_n[k] = (state_n == ST_RUN) ||
                          ((state_n == ST_RELEASE) && (IDX_W'(k) <= stage_idx_n));
        end
        done_n = (state_n == ST_RUN);
    end

    // Previous filtered requests, for rising-edge detection into the cause register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            filt_q  <= '1;
            cause_o <= CAUSE_RST;
        end else begin
            filt_q  <= filt_req;
            cause_o <= cause_n;
        end
    end

    assign filt_rise = filt_req & ~filt_q;

    // Sticky cause bits: a new request edge overrides a simultaneous clear.
    always_comb begin
        cause_n = cause_clr_i ? '0 : cause_o;
        cause_n[N_REQ-1:0] = cause_n[N_REQ-1:0] | filt_rise;
    end

endmodule

// File: tb/tb_pulpemu_rst_seq.sv
// Directed bench for pulpemu_rst_seq with short debounce/hold/stage delays.
module tb_pulpemu_rst_seq;

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic [1:0] src  = 2'b10;
    logic       lock = 1'b1;
    logic       clr  = 1'b0;
    logic [2:0] rst_n;
    logic       done;
    logic [3:0] cause;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pulpemu_rst_seq #(
        .N_SRC           (2),
        .SRC_ACT_LOW     (2'b10),
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (3),
        .N_DOM           (3),
        .STAGE_DELAY     (2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .src_i       (src),
        .lock_i      (lock),
        .cause_clr_i (clr),
        .rst_no      (rst_n),
        .done_o      (done),
        .cause_o     (cause)
    );

    typedef struct {
        string      name;
        logic [1:0] src;
        logic       lock;
        logic       clr;
        int         n;
        logic [2:0] rn;
        logic       done;
        logic [3:0] cause;
    } vec_t;

    vec_t tbl[$];
    int   split;

    function automatic vec_t mk(input string name, input logic [1:0] s, input logic l,
                                input logic c, input int n, input logic [2:0] rn,
                                input logic d, input logic [3:0] ca);
        vec_t v;
        v.name = name; v.src = s; v.lock = l; v.clr = c; v.n = n;
        v.rn = rn; v.done = d; v.cause = ca;
        return v;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [2:0] ern, input logic edone,
                         input logic [3:0] ecause);
        n_vec++;
        if (rst_n !== ern || done !== edone || cause !== ecause) begin
            n_bad++;
            $display("FAIL %s: got rst_no=%b done=%b cause=%b, want rst_no=%b done=%b cause=%b",
                     name, rst_n, done, cause, ern, edone, ecause);
        end
    endtask

    task automatic apply(input vec_t v);
        src  = v.src;
        lock = v.lock;
        clr  = v.clr;
        step(v.n);
        check(v.name, v.rn, v.done, v.cause);
    endtask

    initial begin
        // Edge counts are relative to the last input change of interest.
        tbl.push_back(mk("por_e9",        2'b10, 1, 0, 9, 3'b000, 0, 4'b1000));
        tbl.push_back(mk("por_e10",       2'b10, 1, 0, 1, 3'b001, 0, 4'b1000));
        tbl.push_back(mk("por_e11",       2'b10, 1, 0, 1, 3'b001, 0, 4'b1000));
        tbl.push_back(mk("por_e12",       2'b10, 1, 0, 1, 3'b011, 0, 4'b1000));
        tbl.push_back(mk("por_e14",       2'b10, 1, 0, 2, 3'b111, 1, 4'b1000));
        tbl.push_back(mk("run_stable",    2'b10, 1, 0, 5, 3'b111, 1, 4'b1000));
        tbl.push_back(mk("btn_e1",        2'b11, 1, 0, 1, 3'b111, 1, 4'b1000));
        tbl.push_back(mk("btn_e2",        2'b10, 1, 0, 1, 3'b111, 1, 4'b1000));
        tbl.push_back(mk("btn_e3",        2'b10, 1, 0, 1, 3'b000, 0, 4'b1001));
        tbl.push_back(mk("btn_rel_e9",    2'b10, 1, 0, 7, 3'b000, 0, 4'b1001));
        tbl.push_back(mk("btn_rel_e10",   2'b10, 1, 0, 1, 3'b001, 0, 4'b1001));
        tbl.push_back(mk("btn_rel_e12",   2'b10, 1, 0, 2, 3'b011, 0, 4'b1001));
        tbl.push_back(mk("btn_rel_e14",   2'b10, 1, 0, 2, 3'b111, 1, 4'b1001));
        tbl.push_back(mk("bnc_assert",    2'b11, 1, 0, 4, 3'b000, 0, 4'b1001));
        tbl.push_back(mk("bnc_off3",      2'b10, 1, 0, 3, 3'b000, 0, 4'b1001));
        tbl.push_back(mk("bnc_on1",       2'b11, 1, 0, 1, 3'b000, 0, 4'b1001));
        tbl.push_back(mk("bnc_e9",        2'b10, 1, 0, 9, 3'b000, 0, 4'b1001));
        tbl.push_back(mk("bnc_e10",       2'b10, 1, 0, 1, 3'b001, 0, 4'b1001));
        tbl.push_back(mk("bnc_e14",       2'b10, 1, 0, 4, 3'b111, 1, 4'b1001));
        tbl.push_back(mk("lk_pulse",      2'b11, 1, 0, 1, 3'b111, 1, 4'b1001));
        tbl.push_back(mk("lk_rel_e9",     2'b10, 1, 0, 9, 3'b000, 0, 4'b1001));
        tbl.push_back(mk("lk_rel_e10",    2'b10, 1, 0, 1, 3'b001, 0, 4'b1001));
        tbl.push_back(mk("lk_low2",       2'b10, 0, 0, 2, 3'b011, 0, 4'b1001));
        tbl.push_back(mk("lk_drop",       2'b10, 1, 0, 1, 3'b000, 0, 4'b1101));
        tbl.push_back(mk("lk_re_e9",      2'b10, 1, 0, 8, 3'b000, 0, 4'b1101));
        tbl.push_back(mk("lk_re_e10",     2'b10, 1, 0, 1, 3'b001, 0, 4'b1101));
        split = tbl.size();
        tbl.push_back(mk("por2_e9",       2'b10, 1, 0, 9, 3'b000, 0, 4'b1000));
        tbl.push_back(mk("por2_e10",      2'b10, 1, 0, 1, 3'b001, 0, 4'b1000));
        tbl.push_back(mk("por2_e14",      2'b10, 1, 0, 4, 3'b111, 1, 4'b1000));
        tbl.push_back(mk("race_sync",     2'b00, 1, 0, 2, 3'b111, 1, 4'b1000));
        tbl.push_back(mk("race_clr",      2'b00, 1, 1, 1, 3'b000, 0, 4'b0010));
        tbl.push_back(mk("race_after",    2'b10, 1, 0, 1, 3'b000, 0, 4'b0010));
        tbl.push_back(mk("plain_clr",     2'b10, 1, 1, 1, 3'b000, 0, 4'b0000));
        tbl.push_back(mk("trst_rel_e9",   2'b10, 1, 0, 7, 3'b000, 0, 4'b0000));
        tbl.push_back(mk("trst_rel_e10",  2'b10, 1, 0, 1, 3'b001, 0, 4'b0000));
        tbl.push_back(mk("trst_rel_e14",  2'b10, 1, 0, 4, 3'b111, 1, 4'b0000));
        tbl.push_back(mk("simul_req",     2'b01, 1, 0, 3, 3'b000, 0, 4'b0011));
        tbl.push_back(mk("simul_rel_e10", 2'b10, 1, 0, 10, 3'b001, 0, 4'b0011));
        tbl.push_back(mk("simul_rel_e14", 2'b10, 1, 0, 4, 3'b111, 1, 4'b0011));

        // Power-on: reset values appear before the first clock edge.
        #1 rst = 1'b1;
        #1 check("por_async", 3'b000, 1'b0, 4'b1000);
        step(2);
        check("por_held", 3'b000, 1'b0, 4'b1000);
        rst = 1'b0;

        for (int i = 0; i < split; i++) apply(tbl[i]);

        // Async reset mid-RELEASE (rst_no = 001): no clock edge needed.
        rst = 1'b1;
        #2 check("async_mid_rel", 3'b000, 1'b0, 4'b1000);
        step(2);
        check("async_held", 3'b000, 1'b0, 4'b1000);
        rst = 1'b0;

        for (int i = split; i < tbl.size(); i++) apply(tbl[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
